// File: rtl/shift_unit.sv
// Multi-mode, multi-cycle shift/rotate register: one single-bit step per clock
// under a start/busy/done handshake, with parallel load while idle.
module shift_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic             sin,
  output logic [WIDTH-1:0] dout,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [2:0] M_LSL = 3'b000, M_LSR = 3'b001, M_ASR = 3'b010,
                         M_ROL = 3'b011, M_ROR = 3'b100, M_SIL = 3'b101,
                         M_SIR = 3'b110;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       mode_q, mode_nx;
  logic [WIDTH-1:0] dout_nx, step_d;
  logic             sout_nx, step_s;

  // One step of the latched mode; the reserved encoding holds data and sout.
  always_comb begin
    step_d = dout;
    step_s = sout;
    case (mode_q)
      M_LSL: begin step_d = {dout[WIDTH-2:0], 1'b0};         step_s = dout[WIDTH-1]; end
      M_LSR: begin step_d = {1'b0, dout[WIDTH-1:1]};         step_s = dout[0];       end
      M_ASR: begin step_d = {dout[WIDTH-1], dout[WIDTH-1:1]}; step_s = dout[0];      end
      M_ROL: begin step_d = {dout[WIDTH-2:0], dout[WIDTH-1]}; step_s = dout[WIDTH-1]; end
      M_ROR: begin step_d = {dout[0], dout[WIDTH-1:1]};      step_s = dout[0];       end
      M_SIL: begin step_d = {dout[WIDTH-2:0], sin};          step_s = dout[WIDTH-1]; end
      M_SIR: begin step_d = {sin, dout[WIDTH-1:1]};          step_s = dout[0];       end
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    mode_nx  = mode_q;
    dout_nx  = dout;
    sout_nx  = sout;
    case (state)
      IDLE: begin
        if (load) begin
          dout_nx = din;
        end else if (start) begin
          if (amount == '0) begin
            state_nx = DONE;
          end else begin
            mode_nx  = mode;
            cnt_nx   = amount;
            state_nx = SHIFT;
          end
        end
      end
      SHIFT: begin
        dout_nx = step_d;
        sout_nx = step_s;
        cnt_nx  = cnt - 1'b1;
        if (cnt == CNT_W'(1)) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      mode_q <= '0;
      dout   <= '0;
      sout   <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      mode_q <= mode_nx;
      dout   <= dout_nx;
      sout   <= sout_nx;
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule
